// File: rtl/lector_instrucciones_if.sv
// Half-word instruction memory bus between the fetch unit and a 16-bit
// instruction memory.
//   mem_leer       : one-cycle read strobe (fetch unit -> memory)
//   mem_direccion  : half-word address {word_addr, half_bit}
//   mem_dato       : read data, valid while mem_valido=1 (memory -> fetch unit)
//   mem_valido     : read-data valid strobe
// Modports: master = fetch unit, slave = memory.
interface lector_instrucciones_if #(
    parameter int ANCHO_DIR = 14
);
    logic                 mem_leer;
    logic [ANCHO_DIR:0]   mem_direccion;
    logic [15:0]          mem_dato;
    logic                 mem_valido;

    modport master (
        output mem_leer,
        output mem_direccion,
        input  mem_dato,
        input  mem_valido
    );

    modport slave (
        input  mem_leer,
        input  mem_direccion,
        output mem_dato,
        output mem_valido
    );
endinterface

// File: rtl/lector_instrucciones.sv
// Instruction fetcher: reads a 32-bit instruction as two 16-bit half-words
// (low half first) from a half-word memory and presents it to the core.
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   leer_siguiente_inst       : fetch request, only sampled when idle
//   direccion_siguiente_inst  : word address captured with the request
//   lectura_completada        : one-cycle pulse, instruccion_actual updated
//   instruccion_actual        : last fetched instruction (0 after a timeout)
//   ocupado                   : high whenever a fetch is in progress
//   error_lectura             : sticky timeout flag, cleared by next request
//   mem                       : memory bus (master side)
//
// state        | meaning
// REPOSO       | idle, waiting for a fetch request
// PEDIR_BAJA   | strobe read of low half-word {dir,0}
// ESPERAR_BAJA | wait for low half-word data (bounded)
// PEDIR_ALTA   | strobe read of high half-word {dir,1}
// ESPERAR_ALTA | wait for high half-word data (bounded)
// ENTREGAR     | instruction valid, completion pulse
module lector_instrucciones #(
    parameter int ANCHO_DIR     = 14,
    parameter int TIEMPO_ESPERA = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     leer_siguiente_inst,
    input  logic [ANCHO_DIR-1:0]     direccion_siguiente_inst,
    output logic                     lectura_completada,
    output logic [31:0]              instruccion_actual,
    output logic                     ocupado,
    output logic                     error_lectura,
    lector_instrucciones_if.master   mem
);

    typedef enum logic [2:0] {
        REPOSO,
        PEDIR_BAJA,
        ESPERAR_BAJA,
        PEDIR_ALTA,
        ESPERAR_ALTA,
        ENTREGAR
    } estado_t;

    // Last wait-counter value before giving up: allows TIEMPO_ESPERA wait cycles.
    localparam logic [7:0] ESPERA_FIN = 8'(TIEMPO_ESPERA - 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] dir_q, dir_d;
    logic [15:0]          baja_q, baja_d;
    logic [31:0]          instr_q, instr_d;
    logic                 error_q, error_d;
    logic [7:0]           espera_q, espera_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q <= REPOSO;
            dir_q    <= '0;
            baja_q   <= '0;
            instr_q  <= '0;
            error_q  <= 1'b0;
            espera_q <= '0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            baja_q   <= baja_d;
            instr_q  <= instr_d;
            error_q  <= error_d;
            espera_q <= espera_d;
        end
    end

    always_comb begin
        estado_d           = estado_q;
        dir_d              = dir_q;
        baja_d             = baja_q;
        instr_d            = instr_q;
        error_d            = error_q;
        espera_d           = espera_q;
        mem.mem_leer       = 1'b0;
        mem.mem_direccion  = '0;
        lectura_completada = 1'b0;

        case (estado_q)
            REPOSO: begin
                espera_d = '0;
                if (leer_siguiente_inst) begin
                    dir_d    = direccion_siguiente_inst;
                    error_d  = 1'b0;
                    estado_d = PEDIR_BAJA;
                end
            end

            PEDIR_BAJA: begin
                mem.mem_leer      = 1'b1;
                mem.mem_direccion = {dir_q, 1'b0};
                espera_d          = '0;
                estado_d          = ESPERAR_BAJA;
            end

            ESPERAR_BAJA: begin
                mem.mem_direccion = {dir_q, 1'b0};
                if (mem.mem_valido) begin
                    baja_d   = mem.mem_dato;
                    estado_d = PEDIR_ALTA;
                end else if (espera_q == ESPERA_FIN) begin
                    // Timeout: skip the high half and deliver a zero word.
                    error_d  = 1'b1;
                    instr_d  = '0;
                    estado_d = ENTREGAR;
                end else begin
                    espera_d = espera_q + 8'd1;
                end
            end

            PEDIR_ALTA: begin
                mem.mem_leer      = 1'b1;
                mem.mem_direccion = {dir_q, 1'b1};
                espera_d          = '0;
                estado_d          = ESPERAR_ALTA;
            end

            ESPERAR_ALTA: begin
                mem.mem_direccion = {dir_q, 1'b1};
                if (mem.mem_valido) begin
                    // Loaded on entry so the word is valid during the pulse.
                    instr_d  = {mem.mem_dato, baja_q};
                    estado_d = ENTREGAR;
                end else if (espera_q == ESPERA_FIN) begin
                    error_d  = 1'b1;
                    instr_d  = '0;
                    estado_d = ENTREGAR;
                end else begin
                    espera_d = espera_q + 8'd1;
                end
            end

            ENTREGAR: begin
                lectura_completada = 1'b1;
                estado_d           = REPOSO;
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    assign instruccion_actual = instr_q;
    assign error_lectura      = error_q;
    assign ocupado            = (estado_q != REPOSO);

endmodule
